alu_rsp_rx: RTL and testbench
=============================

Name: alu_rsp_rx

Overview:
- Receiver for the ALU's serial response stream (DUT `sout`).
- Deserialises 11-bit packets and assembles one complete response: 4 DATA packets plus 1 CTL packet, or 1 error CTL packet.
- Checks framing, CRC and parity, then presents the decoded result as a one-cycle-valid record.
- Sits on the testbench/system side, opposite the ALU's serial transmitter.

Parameters:
- DATA_PKTS, 4, number of DATA packets in a normal response (bytes of C, MSB byte first).
- CRC_W, 3, width of the response CRC.

Ports:
- clk  in  1  system clock; one serial bit per rising edge.
- rst_n  in  1  synchronous active-low reset.
- sout  in  1  serial response line from the ALU; idles high.
- rsp_valid  out  1  one-cycle pulse, response complete.
- rsp_data  out  32  result C (signed); 0 for error responses.
- rsp_flags  out  6  normal response: {2'b00, CARRY, OVFL, ZERO, NEG}; error response: the 6 error bits as received.
- rsp_is_err  out  1  response was an error packet (CTL packet with bit7=1).
- rsp_chk_ok  out  1  CRC (normal) or parity (error) matched.
- rsp_proto_err  out  1  packet sequence violated; rsp_data/rsp_flags are don't-care.
- busy  out  1  high from start bit until rsp_valid.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: all outputs 0; packet FSM in IDLE; DATA count 0; shift registers cleared. Reset asserted mid-packet discards the partial response, and no rsp_valid is generated for it.
- Packet format, bit 10 first: start(0), cmd (0=DATA, 1=CTL), byte[7:0] MSB first, stop(1). 1 bit per clk, no oversampling.
- Packet FSM:
  - IDLE: waits for sout=0.
  - CMD: sample cmd.
  - BYTE: 8 cycles, bit counter 7..0.
  - STOP: sample stop.
  - Back-to-back packets are legal: a start bit may directly follow the stop bit.
- Framing error: stop bit = 0. Go to RESYNC, which waits for sout=1, then IDLE. Emit a response with rsp_proto_err=1.
- Response assembly:
  - DATA packets shift into C; the first DATA byte is C[31:24].
  - A 5th DATA packet before CTL is a protocol error.
  - CTL with bit7=0 and DATA count ≠ DATA_PKTS is a protocol error.
  - CTL with bit7=1 and DATA count ≠ 0 is a protocol error.
  - On any protocol error, emit rsp_valid with rsp_proto_err=1 and reset the count.
- Normal CTL byte = {0, flags[3:0], crc[2:0]}.
  - CRC3: polynomial x^3+x+1, init 0, computed over the 36-bit message {C[31:0], flags[3:0]}, MSB first.
  - rsp_chk_ok = (received crc == computed crc).
- Error CTL byte = {1, err[5:0], p}, with p = ^byte[7:1] (even parity over the whole byte).
  - rsp_chk_ok = (p matches). rsp_data = 0.
- Latency: rsp_valid is high exactly 1 cycle, on the cycle after the CTL stop bit is sampled. Outputs hold their value until the next rsp_valid.
- busy is set at the first start bit of a response and falls when rsp_valid is asserted.
- Simultaneous events: a start bit on the same cycle rsp_valid is asserted is accepted.
- rsp_chk_ok = 0 never suppresses rsp_valid.

Decomposition:
- Shared package alu_pkg. Add:
  - the packet-FSM enum {IDLE, CMD, BYTE, STOP, RESYNC};
  - constants for the CRC3 polynomial and DATA_PKTS;
  - function crc3(bit [35:0]);
  - function par8.
- Reuse from alu_pkg: cmd_t, alu_t bit positions, err_t, alu_result_t.
- Sub-module alu_pkt_rx: single-packet deserialiser.
  - Outputs pkt_valid, pkt_cmd (cmd_t), pkt_byte[7:0], pkt_frame_err.
  - alu_rsp_rx holds the response-level sequencer and the checks.

Test Plan:
- Normal response, zero result: 4 DATA packets 0x00 then CTL 0x16 (flags 0010, crc 110) -> rsp_valid 1 cycle after the CTL stop bit; rsp_data=0, rsp_flags=6'b000010, rsp_is_err=0, rsp_chk_ok=1.
- Same stream with CTL 0x17 (crc corrupted) -> rsp_valid, rsp_chk_ok=0, rsp_data=0.
- Error response, CTL 0x93 (err 001001, p=1) -> rsp_is_err=1, rsp_flags=6'b001001, rsp_chk_ok=1; 0x92 -> rsp_chk_ok=0.
- Framing: a DATA packet with stop=0 -> rsp_proto_err=1; resync; the next valid response decodes correctly.
- Sequence errors -> rsp_proto_err=1 in each case:
  - 3 DATA packets then a normal CTL;
  - 5 DATA packets;
  - 2 DATA packets then an error CTL.
- Reset and back-to-back:
  - rst_n low for 1 cycle in the middle of DATA packet 2 -> no rsp_valid, outputs 0; a following full response decodes correctly.
  - Two responses with zero idle gap -> two rsp_valid pulses, both correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the response receiver.
// Provides the packet command type, flag bit positions, error field type,
// the decoded response record, the packet-FSM state type, CRC3/parity
// helpers and the response-shape constants.
package alu_pkg;

  // Packet command bit: DATA carries one byte of C, CTL closes a response.
  typedef enum logic {
    CMD_DATA = 1'b0,
    CMD_CTL  = 1'b1
  } cmd_t;

  // Bit positions of the ALU status flags inside rsp_flags.
  localparam int unsigned FLG_NEG   = 0;
  localparam int unsigned FLG_ZERO  = 1;
  localparam int unsigned FLG_OVFL  = 2;
  localparam int unsigned FLG_CARRY = 3;

  typedef logic [5:0] err_t;

  // Decoded response as presented on the rsp_* outputs.
  typedef struct packed {
    logic [31:0] c;
    err_t        flags;
    logic        is_err;
    logic        chk_ok;
    logic        proto_err;
  } alu_result_t;

  // Single-packet deserialiser states.
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    BYTE,
    STOP,
    RESYNC
  } pkt_state_t;

  localparam int unsigned ALU_DATA_PKTS = 4;
  localparam int unsigned ALU_CRC_W     = 3;
  // x^3 + x + 1
  localparam logic [3:0]  CRC3_POLY     = 4'b1011;

  // CRC3 over {C, flags}, MSB first, init 0.
  function automatic logic [ALU_CRC_W-1:0] crc3(input bit [35:0] msg);
    logic [ALU_CRC_W-1:0] crc;
    logic                 fb;
    crc = '0;
    for (int unsigned i = 0; i < 36; i++) begin
      fb  = crc[2] ^ msg[35-i];
      crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY[2:0] : 3'b000);
    end
    return crc;
  endfunction

  // Parity over a whole byte; 0 means even parity holds.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/alu_rsp_rx_if.sv
// Bundle between the ALU serial transmitter side and the response receiver.
//   sout          : serial response line (idles high)
//   rsp_valid     : one-cycle pulse, response complete
//   rsp_data      : result C, 0 for error responses
//   rsp_flags     : {00,CARRY,OVFL,ZERO,NEG} or the 6 received error bits
//   rsp_is_err    : response was an error CTL packet
//   rsp_chk_ok    : CRC (normal) or parity (error) matched
//   rsp_proto_err : packet sequence or framing violated
//   busy          : response in progress
interface alu_rsp_rx_if;
  logic        sout;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_flags;
  logic        rsp_is_err;
  logic        rsp_chk_ok;
  logic        rsp_proto_err;
  logic        busy;

  // Transmitter / system side.
  modport master (
    output sout,
    input  rsp_valid, rsp_data, rsp_flags, rsp_is_err, rsp_chk_ok,
           rsp_proto_err, busy
  );

  // Receiver side.
  modport slave (
    input  sout,
    output rsp_valid, rsp_data, rsp_flags, rsp_is_err, rsp_chk_ok,
           rsp_proto_err, busy
  );
endinterface

// File: rtl/alu_pkt_rx.sv
// Single-packet deserialiser for the ALU response line.
// Packet, first bit first: start(0), cmd, byte[7:0] MSB first, stop(1).
//   clk, rst_n    : clock, synchronous active-low reset
//   sout          : serial input
//   pkt_start     : start bit seen in IDLE this cycle
//   pkt_valid     : stop bit good this cycle; pkt_cmd/pkt_byte are complete
//   pkt_frame_err : stop bit was 0 this cycle
//   pkt_cmd       : received command bit
//   pkt_byte      : received byte
// Status outputs are combinational on the sampling cycle so the consumer can
// register its result on the same edge that samples the stop bit.
module alu_pkt_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       pkt_start,
  output logic       pkt_valid,
  output logic       pkt_frame_err,
  output cmd_t       pkt_cmd,
  output logic [7:0] pkt_byte
);

  pkt_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= CMD_DATA;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    cmd_d         = cmd_q;
    shift_d       = shift_q;
    pkt_start     = 1'b0;
    pkt_valid     = 1'b0;
    pkt_frame_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sout) begin
          pkt_start = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        cmd_d     = cmd_t'(sout);
        bit_cnt_d = 3'd7;
        state_d   = BYTE;
      end
      BYTE: begin
        shift_d = {shift_q[6:0], sout};
        if (bit_cnt_q == 3'd0) begin
          state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      STOP: begin
        // Returning straight to IDLE lets a start bit follow immediately.
        if (sout) begin
          pkt_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          pkt_frame_err = 1'b1;
          state_d       = RESYNC;
        end
      end
      RESYNC: begin
        if (sout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_cmd  = cmd_q;
  assign pkt_byte = shift_q;

endmodule

// File: rtl/alu_rsp_rx.sv
// ALU response receiver: assembles DATA/CTL packets into one response,
// checks sequence, CRC3 and parity, and presents a one-cycle-valid record.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : slave side of alu_rsp_rx_if (sout in, rsp_* and busy out)
// Parameters: DATA_PKTS DATA packets per normal response, CRC_W CRC width.
module alu_rsp_rx
  import alu_pkg::*;
#(
  parameter int unsigned DATA_PKTS = ALU_DATA_PKTS,
  parameter int unsigned CRC_W     = ALU_CRC_W
) (
  input logic          clk,
  input logic          rst_n,
  alu_rsp_rx_if.slave  rx
);

  localparam int unsigned       CNT_W    = $clog2(DATA_PKTS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_PKTS);

  logic       pkt_start;
  logic       pkt_valid;
  logic       pkt_frame_err;
  cmd_t       pkt_cmd;
  logic [7:0] pkt_byte;

  alu_pkt_rx u_pkt_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .sout          (rx.sout),
    .pkt_start     (pkt_start),
    .pkt_valid     (pkt_valid),
    .pkt_frame_err (pkt_frame_err),
    .pkt_cmd       (pkt_cmd),
    .pkt_byte      (pkt_byte)
  );

  alu_result_t       rsp_q, rsp_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       c_q, c_d;

  logic [3:0]        flags_rx;
  logic [CRC_W-1:0]  crc_calc;
  logic              crc_ok;
  logic              par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      rsp_q   <= rsp_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  // Checks evaluated against the CTL byte currently on pkt_byte.
  always_comb begin
    flags_rx = pkt_byte[6:3];
    crc_calc = CRC_W'(crc3({c_q, flags_rx}));
    crc_ok   = (pkt_byte[CRC_W-1:0] == crc_calc);
    par_ok   = (par8(pkt_byte) == 1'b0);
  end

  always_comb begin
    rsp_d   = rsp_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    c_d     = c_q;

    if (pkt_start) begin
      busy_d = 1'b1;
    end

    if (pkt_frame_err) begin
      valid_d         = 1'b1;
      rsp_d           = '0;
      rsp_d.proto_err = 1'b1;
      cnt_d           = '0;
      c_d             = '0;
    end else if (pkt_valid) begin
      if (pkt_cmd == CMD_DATA) begin
        if (cnt_q == CNT_FULL) begin
          // One DATA packet too many: report and start counting afresh.
          valid_d         = 1'b1;
          rsp_d           = '0;
          rsp_d.proto_err = 1'b1;
          cnt_d           = '0;
          c_d             = '0;
        end else begin
          c_d   = {c_q[23:0], pkt_byte};
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        valid_d = 1'b1;
        cnt_d   = '0;
        c_d     = '0;
        rsp_d   = '0;
        if (!pkt_byte[7]) begin
          if (cnt_q != CNT_FULL) begin
            rsp_d.proto_err = 1'b1;
          end else begin
            rsp_d.c                = c_q;
            rsp_d.flags[FLG_CARRY] = pkt_byte[6];
            rsp_d.flags[FLG_OVFL]  = pkt_byte[5];
            rsp_d.flags[FLG_ZERO]  = pkt_byte[4];
            rsp_d.flags[FLG_NEG]   = pkt_byte[3];
            rsp_d.chk_ok           = crc_ok;
          end
        end else begin
          if (cnt_q != '0) begin
            rsp_d.proto_err = 1'b1;
          end else begin
            rsp_d.flags  = err_t'(pkt_byte[6:1]);
            rsp_d.is_err = 1'b1;
            rsp_d.chk_ok = par_ok;
          end
        end
      end
    end

    if (valid_d) begin
      busy_d = 1'b0;
    end
  end

  assign rx.rsp_valid     = valid_q;
  assign rx.rsp_data      = rsp_q.c;
  assign rx.rsp_flags     = rsp_q.flags;
  assign rx.rsp_is_err    = rsp_q.is_err;
  assign rx.rsp_chk_ok    = rsp_q.chk_ok;
  assign rx.rsp_proto_err = rsp_q.proto_err;
  assign rx.busy          = busy_q;

endmodule

// File: tb/tb_alu_rsp_rx.sv
// Self-checking bench for alu_rsp_rx: directed cases plus randomised
// responses compared against a reference built from the packet rules.
module tb_alu_rsp_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rsp_rx_if bus ();

  alu_rsp_rx #(.DATA_PKTS(4), .CRC_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  logic        cap_valid = 1'b0;
  logic [31:0] cap_data  = '0;
  logic [5:0]  cap_flags = '0;
  logic        cap_err   = 1'b0;
  logic        cap_ok    = 1'b0;
  logic        cap_proto = 1'b0;
  logic        cap_busy  = 1'b0;
  logic        busy_at_start = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^3 divided by x^3+x+1.
  function automatic logic [2:0] ref_crc(input logic [35:0] m);
    logic [38:0] r;
    r = {m, 3'b000};
    for (int i = 38; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  // Drive one bit for one clock, sample outputs 1 time unit after the edge.
  task automatic send_bit(input logic b);
    bus.sout = b;
    @(posedge clk);
    #1;
    cap_valid = bus.rsp_valid;
    if (bus.rsp_valid === 1'b1) begin
      pulses++;
      cap_data  = bus.rsp_data;
      cap_flags = bus.rsp_flags;
      cap_err   = bus.rsp_is_err;
      cap_ok    = bus.rsp_chk_ok;
      cap_proto = bus.rsp_proto_err;
      cap_busy  = bus.busy;
    end
  endtask

  task automatic send_pkt(input logic cmd, input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    busy_at_start = bus.busy;
    send_bit(cmd);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic expect_rsp(input string tag, input int p0, input logic exp_proto,
                            input logic [31:0] exp_data, input logic [5:0] exp_flags,
                            input logic exp_err, input logic exp_ok);
    chk1({tag, "/valid_after_stop"}, cap_valid, 1'b1);
    chk32({tag, "/pulse_count"}, pulses, p0 + 1);
    chk1({tag, "/proto_err"}, cap_proto, exp_proto);
    chk1({tag, "/busy_low_at_valid"}, cap_busy, 1'b0);
    if (!exp_proto) begin
      chk32({tag, "/data"}, cap_data, exp_data);
      chk32({tag, "/flags"}, 32'(cap_flags), 32'(exp_flags));
      chk1({tag, "/is_err"}, cap_err, exp_err);
      chk1({tag, "/chk_ok"}, cap_ok, exp_ok);
    end
  endtask

  task automatic normal_rsp(input string tag, input logic [31:0] c, input logic [3:0] f,
                            input logic corrupt, input int gap);
    logic [2:0] crc;
    int p0;
    crc = ref_crc({c, f});
    if (corrupt) crc = crc ^ 3'b001;
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      send_pkt(1'b0, c[31 - 8*k -: 8], 1'b1);
      if (k == 0) chk1({tag, "/busy_after_start"}, busy_at_start, 1'b1);
    end
    send_pkt(1'b1, {1'b0, f, crc}, 1'b1);
    expect_rsp(tag, p0, 1'b0, c, {2'b00, f}, 1'b0, !corrupt);
    repeat (gap) send_bit(1'b1);
  endtask

  task automatic err_rsp(input string tag, input logic [5:0] e, input logic bad_p, input int gap);
    logic p;
    int p0;
    p  = (^{1'b1, e}) ^ bad_p;
    p0 = pulses;
    send_pkt(1'b1, {1'b1, e, p}, 1'b1);
    expect_rsp(tag, p0, 1'b0, 32'h0, e, 1'b1, !bad_p);
    repeat (gap) send_bit(1'b1);
  endtask

  initial begin
    int p0;
    bus.sout = 1'b1;
    rst_n    = 1'b0;
    repeat (3) send_bit(1'b1);
    chk1("reset/valid", bus.rsp_valid, 1'b0);
    chk32("reset/data", bus.rsp_data, 32'h0);
    chk32("reset/flags", 32'(bus.rsp_flags), 32'h0);
    chk1("reset/is_err", bus.rsp_is_err, 1'b0);
    chk1("reset/chk_ok", bus.rsp_chk_ok, 1'b0);
    chk1("reset/proto", bus.rsp_proto_err, 1'b0);
    chk1("reset/busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    normal_rsp("zero_ctl16", 32'h0, 4'b0010, 1'b0, 2);
    normal_rsp("zero_ctl17", 32'h0, 4'b0010, 1'b1, 2);
    err_rsp("err_93", 6'b001001, 1'b0, 2);
    err_rsp("err_92", 6'b001001, 1'b1, 2);

    // Framing error on a DATA packet, then resync and decode normally.
    p0 = pulses;
    send_pkt(1'b0, 8'hA5, 1'b0);
    expect_rsp("framing", p0, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
    repeat (3) send_bit(1'b1);
    normal_rsp("after_framing", 32'h12345678, 4'b1001, 1'b0, 2);

    // Three DATA packets then a normal CTL.
    p0 = pulses;
    for (int k = 0; k < 3; k++) send_pkt(1'b0, 8'h3C, 1'b1);
    send_pkt(1'b1, 8'h16, 1'b1);
    expect_rsp("seq_3data", p0, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
    repeat (2) send_bit(1'b1);

    // Five DATA packets: the fifth is the violation.
    p0 = pulses;
    for (int k = 0; k < 5; k++) send_pkt(1'b0, 8'h5A, 1'b1);
    expect_rsp("seq_5data", p0, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
    repeat (2) send_bit(1'b1);

    // Two DATA packets then an error CTL.
    p0 = pulses;
    for (int k = 0; k < 2; k++) send_pkt(1'b0, 8'hC3, 1'b1);
    send_pkt(1'b1, 8'h93, 1'b1);
    expect_rsp("seq_2data_err", p0, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0);
    repeat (2) send_bit(1'b1);

    // Reset in the middle of DATA packet 2.
    normal_rsp("pre_reset", 32'hDEADBEEF, 4'b1100, 1'b0, 2);
    p0 = pulses;
    send_pkt(1'b0, 8'h11, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    send_bit(1'b1);
    rst_n = 1'b1;
    chk32("midreset/no_pulse", pulses, p0);
    chk32("midreset/data", bus.rsp_data, 32'h0);
    chk32("midreset/flags", 32'(bus.rsp_flags), 32'h0);
    chk1("midreset/chk_ok", bus.rsp_chk_ok, 1'b0);
    chk1("midreset/busy", bus.busy, 1'b0);
    repeat (2) send_bit(1'b1);
    chk32("midreset/no_pulse_later", pulses, p0);
    normal_rsp("post_reset", 32'h80000001, 4'b0101, 1'b0, 2);

    // Back-to-back responses with zero idle gap.
    normal_rsp("b2b_a", 32'hCAFE0123, 4'b1010, 1'b0, 0);
    err_rsp("b2b_b", 6'b110101, 1'b0, 0);
    normal_rsp("b2b_c", 32'h7FFFFFFF, 4'b0100, 1'b0, 2);

    // Randomised responses.
    for (int n = 0; n < 24; n++) begin
      int unsigned kind;
      int unsigned gap;
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      if (kind < 3) begin
        normal_rsp("rand_normal", $urandom, 4'($urandom), ($urandom_range(0, 3) == 0), int'(gap));
      end else begin
        err_rsp("rand_err", 6'($urandom), 1'($urandom_range(0, 1)), int'(gap));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
